// File: rtl/dram_preload_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dram_preload_pkg
// Brief   : Shared types, DRAM window defaults and address translation helper
//           for the DRAM preload controller.
// Revision: 1.0 - initial release
// ============================================================================
package dram_preload_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [63:0] DRAM_BASE_DEFAULT   = 64'h0000_0000_8000_0000;
    localparam logic [63:0] DRAM_LENGTH_DEFAULT = 64'h0000_0000_4000_0000;

    // Caller truncates the result to its row-index width.
    function automatic logic [63:0] addr_to_row(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned shift
    );
        return (addr - base) >> shift;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_preload_hold_cnt.sv
`default_nettype none
// ============================================================================
// Module  : dram_preload_hold_cnt
// Brief   : 8-bit down-counter with parallel load; done flags the final count.
// Revision: 1.0 - initial release
// ============================================================================
module dram_preload_hold_cnt (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       dec_i,
    output logic       done_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == 8'd1);

endmodule
`default_nettype wire

// File: rtl/dram_preload_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dram_preload_ctrl
// Brief   : Sequences the DRAM SRAM port from preload (core in reset) to the
//           runtime requester. Define DRAM_PRELOAD_CHECKSUM_EN for csum_o.
// Revision: 1.0 - initial release
// ============================================================================
module dram_preload_ctrl
    import dram_preload_pkg::*;
#(
    parameter int          AddrWidth  = 64,
    parameter int          DataWidth  = 128,
    parameter logic [63:0] DramBase   = DRAM_BASE_DEFAULT,
    parameter logic [63:0] DramLength = DRAM_LENGTH_DEFAULT,
    parameter int          HoldCycles = 4,
    localparam int         BeWidth      = DataWidth / 8,
    localparam int         ByteOffset   = $clog2(BeWidth),
    localparam int         MemAddrWidth = $clog2(DramLength / BeWidth)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    pl_valid_i,
    output logic                    pl_ready_o,
    input  logic [AddrWidth-1:0]    pl_addr_i,
    input  logic [DataWidth-1:0]    pl_data_i,
    input  logic                    pl_last_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic                    we_i,
    input  logic [AddrWidth-1:0]    addr_i,
    input  logic [DataWidth-1:0]    wdata_i,
    input  logic [BeWidth-1:0]      be_i,
    output logic                    rvalid_o,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [MemAddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    output logic [BeWidth-1:0]      mem_be_o,
    input  logic [DataWidth-1:0]    mem_rdata_i,
    output logic                    core_rst_o,
    output logic                    run_o,
    output logic [31:0]             rows_o,
    output logic [15:0]             oob_cnt_o
`ifdef DRAM_PRELOAD_CHECKSUM_EN
    ,
    output logic [DataWidth-1:0]    csum_o
`endif
);

    state_e      state_q;
    logic        core_rst_q;
    logic        run_q;
    logic        rvalid_q;
    logic [31:0] rows_q;
    logic [31:0] rows_d;
    logic [15:0] oob_q;
    logic [15:0] oob_d;
    logic        w_hold_done;

    logic [63:0]             w_pl_addr;
    logic                    w_pl_inwin;
    logic                    w_pl_hs;
    logic [MemAddrWidth-1:0] w_pl_row;
    logic [MemAddrWidth-1:0] w_rt_row;

    assign w_pl_addr  = 64'(pl_addr_i);
    assign w_pl_inwin = (w_pl_addr >= DramBase) && ((w_pl_addr - DramBase) < DramLength);
    assign w_pl_row   = MemAddrWidth'(addr_to_row(w_pl_addr, DramBase, ByteOffset));
    assign w_rt_row   = MemAddrWidth'(addr_to_row(64'(addr_i), DramBase, ByteOffset));

    // Ready is masked by rst_i so it reads 0 while reset is held.
    assign pl_ready_o = (state_q == LOAD) && !rst_i;
    assign w_pl_hs    = pl_valid_i && pl_ready_o;
    assign gnt_o      = (state_q == RUN) && req_i;

    always_comb begin
        rows_d = rows_q;
        oob_d  = oob_q;
        if (w_pl_hs) begin
            if (w_pl_inwin) begin
                rows_d = rows_q + 32'd1;
            end else if (oob_q != 16'hFFFF) begin
                oob_d = oob_q + 16'd1;
            end
        end
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (state_q == LOAD) begin
            mem_req_o   = w_pl_hs && w_pl_inwin;
            mem_we_o    = 1'b1;
            mem_addr_o  = w_pl_row;
            mem_wdata_o = pl_data_i;
            mem_be_o    = '1;
        end else if (state_q == RUN) begin
            mem_req_o   = req_i;
            mem_we_o    = we_i;
            mem_addr_o  = w_rt_row;
            mem_wdata_o = wdata_i;
            mem_be_o    = be_i;
        end
    end

    dram_preload_hold_cnt u_hold_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_pl_hs && pl_last_i),
        .load_val_i (8'(HoldCycles)),
        .dec_i      (state_q == HOLD),
        .done_o     (w_hold_done)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= LOAD;
            core_rst_q <= 1'b1;
            run_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rows_q     <= 32'd0;
            oob_q      <= 16'd0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    rows_q <= rows_d;
                    oob_q  <= oob_d;
                    if (w_pl_hs && pl_last_i) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_hold_done) begin
                        state_q    <= RUN;
                        core_rst_q <= 1'b0;
                        run_q      <= 1'b1;
                    end
                end
                RUN: begin
                    rvalid_q <= req_i && !we_i;
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

`ifdef DRAM_PRELOAD_CHECKSUM_EN
    logic [DataWidth-1:0] csum_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csum_q <= '0;
        end else if ((state_q == LOAD) && w_pl_hs && w_pl_inwin) begin
            csum_q <= csum_q ^ pl_data_i;
        end
    end

    assign csum_o = csum_q;
`endif

    assign core_rst_o = core_rst_q;
    assign run_o      = run_q;
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = mem_rdata_i;
    assign rows_o     = rows_q;
    assign oob_cnt_o  = oob_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_preload_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dram_preload_ctrl
// Brief   : Directed self-checking bench with SRAM model and request scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dram_preload_ctrl;

    localparam int DW = 128;
    localparam int BW = 16;
    localparam int MW = 26;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          pl_valid_i;
    logic          pl_ready_o;
    logic [63:0]   pl_addr_i;
    logic [DW-1:0] pl_data_i;
    logic          pl_last_i;
    logic          req_i;
    logic          gnt_o;
    logic          we_i;
    logic [63:0]   addr_i;
    logic [DW-1:0] wdata_i;
    logic [BW-1:0] be_i;
    logic          rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [MW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [BW-1:0] mem_be_o;
    logic [DW-1:0] mem_rdata_i;
    logic          core_rst_o;
    logic          run_o;
    logic [31:0]   rows_o;
    logic [15:0]   oob_cnt_o;
`ifdef DRAM_PRELOAD_CHECKSUM_EN
    logic [DW-1:0] csum_o;
`endif

    always #5 clk = ~clk;

    dram_preload_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .pl_valid_i  (pl_valid_i),
        .pl_ready_o  (pl_ready_o),
        .pl_addr_i   (pl_addr_i),
        .pl_data_i   (pl_data_i),
        .pl_last_i   (pl_last_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_rdata_i (mem_rdata_i),
        .core_rst_o  (core_rst_o),
        .run_o       (run_o),
        .rows_o      (rows_o),
`ifdef DRAM_PRELOAD_CHECKSUM_EN
        .oob_cnt_o   (oob_cnt_o),
        .csum_o      (csum_o)
`else
        .oob_cnt_o   (oob_cnt_o)
`endif
    );

    typedef struct {
        logic          we;
        logic [MW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } mreq_t;

    mreq_t         mq[$];
    logic [DW-1:0] rq[$];
    int            vectors     = 0;
    int            miscompares = 0;

    logic [DW-1:0] mem [0:63] = '{default: '0};

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SRAM model: byte-masked write, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_req_o === 1'b1) begin
            if (mem_we_o) begin
                for (int b = 0; b < BW; b++) begin
                    if (mem_be_o[b]) mem[mem_addr_o[5:0]][b*8 +: 8] = mem_wdata_o[b*8 +: 8];
                end
            end else begin
                mem_rdata_i <= mem[mem_addr_o[5:0]];
            end
        end
    end

    always @(negedge clk) begin
        mreq_t e;
        if (mem_req_o === 1'b1) begin
            if (mq.size() == 0) begin
                check("mem_req_unexpected", DW'(mem_req_o), '0);
            end else begin
                e = mq.pop_front();
                check("mem_we", DW'(mem_we_o), DW'(e.we));
                check("mem_addr", DW'(mem_addr_o), DW'(e.addr));
                check("mem_be", DW'(mem_be_o), DW'(e.be));
                if (e.we) check("mem_wdata", mem_wdata_o, e.wdata);
            end
        end
        if (rvalid_o === 1'b1) begin
            if (rq.size() == 0) check("rvalid_unexpected", DW'(rvalid_o), '0);
            else check("rdata", rdata_o, rq.pop_front());
        end
    end

    task automatic preload_row(input logic [63:0] a, input logic [DW-1:0] d, input logic last,
                               input logic inwin, input logic [MW-1:0] row);
        pl_valid_i = 1'b1;
        pl_addr_i  = a;
        pl_data_i  = d;
        pl_last_i  = last;
        if (inwin) mq.push_back('{we: 1'b1, addr: row, wdata: d, be: {BW{1'b1}}});
        @(negedge clk);
        check("pl_ready_load", DW'(pl_ready_o), DW'(1));
        check("gnt_load", DW'(gnt_o), '0);
        @(posedge clk); #1;
        pl_valid_i = 1'b0;
        pl_last_i  = 1'b0;
    endtask

    localparam logic [DW-1:0] D0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [DW-1:0] D1 = 128'h89AB_CDEF_0123_4567_FEDC_BA98_7654_3210;
    localparam logic [DW-1:0] D2 = 128'hCAFE_F00D_DEAD_BEEF_0BAD_C0DE_1234_5678;

    initial begin
        rst_i = 1'b1;  pl_valid_i = 1'b0; pl_addr_i = '0; pl_data_i = '0; pl_last_i = 1'b0;
        req_i = 1'b1;  we_i = 1'b0; addr_i = 64'h8000_0010; wdata_i = '0; be_i = '0;
        #2;
        check("rst_core_rst", DW'(core_rst_o), DW'(1));
        check("rst_run", DW'(run_o), '0);
        check("rst_pl_ready", DW'(pl_ready_o), '0);
        check("rst_gnt", DW'(gnt_o), '0);
        check("rst_rvalid", DW'(rvalid_o), '0);
        check("rst_mem_req", DW'(mem_req_o), '0);
        check("rst_rows", DW'(rows_o), '0);
        check("rst_oob", DW'(oob_cnt_o), '0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        #1 check("pl_ready_after_rst", DW'(pl_ready_o), DW'(1));

        // Three in-window rows, runtime request held pending throughout.
        preload_row(64'h8000_0000, D0, 1'b0, 1'b1, 26'd0);
        preload_row(64'h8000_0010, D1, 1'b0, 1'b1, 26'd1);
        preload_row(64'h8000_0020, D2, 1'b1, 1'b1, 26'd2);
        check("rows_after_load", DW'(rows_o), DW'(3));
        pl_valid_i = 1'b1; pl_addr_i = 64'h8000_0030;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_core_rst", DW'(core_rst_o), DW'(1));
            check("hold_pl_ready", DW'(pl_ready_o), '0);
            check("hold_gnt", DW'(gnt_o), '0);
            @(posedge clk); #1;
        end
        pl_valid_i = 1'b0;
        mq.push_back('{we: 1'b0, addr: 26'd1, wdata: '0, be: '0});
        rq.push_back(D1);
        @(negedge clk);
        check("run_core_rst", DW'(core_rst_o), '0);
        check("run_run", DW'(run_o), DW'(1));
        check("run_first_gnt", DW'(gnt_o), DW'(1));
        @(posedge clk); #1 req_i = 1'b0;
        @(negedge clk);
        check("rvalid_row1", DW'(rvalid_o), DW'(1));

        // Partial write then read-back of the same row.
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b1; addr_i = 64'h8000_0040; be_i = 16'h000F;
        wdata_i = {{14{8'hA5}}, 16'hDEAD};
        mq.push_back('{we: 1'b1, addr: 26'd4, wdata: wdata_i, be: 16'h000F});
        @(negedge clk);
        check("gnt_write", DW'(gnt_o), DW'(1));
        @(posedge clk); #1;
        we_i = 1'b0;
        mq.push_back('{we: 1'b0, addr: 26'd4, wdata: '0, be: 16'h000F});
        rq.push_back(128'hA5A5_DEAD);
        @(negedge clk);
        check("no_rvalid_after_write", DW'(rvalid_o), '0);
        @(posedge clk); #1 req_i = 1'b0;
        @(negedge clk);
        check("rvalid_row4", DW'(rvalid_o), DW'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("rvalid_single", DW'(rvalid_o), '0);

        // Asynchronous reset from RUN, then mid-LOAD.
        @(posedge clk); #1 rst_i = 1'b1;
        #1;
        check("arst_core_rst", DW'(core_rst_o), DW'(1));
        check("arst_run", DW'(run_o), '0);
        check("arst_rows", DW'(rows_o), '0);
        @(posedge clk); #1 rst_i = 1'b0;
        #1;
        preload_row(64'h8000_0000, D2, 1'b0, 1'b1, 26'd0);
        preload_row(64'h8000_0010, D0, 1'b0, 1'b1, 26'd1);
        check("rows_mid_load", DW'(rows_o), DW'(2));
        rst_i = 1'b1;
        #1;
        check("midload_rows", DW'(rows_o), '0);
        check("midload_core_rst", DW'(core_rst_o), DW'(1));
        check("midload_pl_ready", DW'(pl_ready_o), '0);
        @(posedge clk); #1 rst_i = 1'b0;
        #1;

        // Out-of-window rows around both window edges, unaligned in-window row.
        preload_row(64'h0000_1000, {DW{1'b1}}, 1'b0, 1'b0, '0);
        preload_row(64'h7FFF_FFF0, {DW{1'b1}}, 1'b0, 1'b0, '0);
        preload_row(64'hC000_0000, {DW{1'b1}}, 1'b0, 1'b0, '0);
        preload_row(64'h8000_0027, 128'h1, 1'b0, 1'b1, 26'd2);
        preload_row(64'hBFFF_FFF0, 128'h3, 1'b1, 1'b1, 26'h3FF_FFFF);
        check("oob_cnt", DW'(oob_cnt_o), DW'(3));
        check("rows_oob_case", DW'(rows_o), DW'(2));
`ifdef DRAM_PRELOAD_CHECKSUM_EN
        check("csum_load", csum_o, 128'h2);
`endif
        begin
            int n = 0;
            while (run_o !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("run_timeout", DW'(run_o), DW'(1));
        end
        req_i = 1'b1; we_i = 1'b1; addr_i = 64'h8000_0020; be_i = '1; wdata_i = {DW{1'b1}};
        mq.push_back('{we: 1'b1, addr: 26'd2, wdata: {DW{1'b1}}, be: {BW{1'b1}}});
        @(negedge clk);
        check("gnt_run2", DW'(gnt_o), DW'(1));
        @(posedge clk); #1 req_i = 1'b0;
`ifdef DRAM_PRELOAD_CHECKSUM_EN
        check("csum_frozen", csum_o, 128'h2);
`endif
        check("oob_stable_run", DW'(oob_cnt_o), DW'(3));

        repeat (2) @(posedge clk);
        #1 check("scoreboard_drained", DW'(mq.size() + rq.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
